// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for a simple processor bus.
//   Accepts one request at a time from IDLE, optionally waits LATENCY cycles,
//   then presents a one-cycle response (ready/rdata/err) in RESP.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-low reset; clears FSM, outputs and memory
//   req    - request strobe, sampled only in IDLE
//   we     - 1 = write, 0 = read
//   size   - 00 byte, 01 halfword, 10 word, 11 illegal
//   addr   - byte address
//   wdata  - right-justified write data
//   ready  - one-cycle response pulse
//   rdata  - containing word for reads (0 for writes/errors), valid with ready
//   err    - error flag, valid with ready
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] LIMIT    = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam bit          NO_WAIT  = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  // request captured on the accepting edge
  logic        we_p0;
  logic [1:0]  size_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic          op_we;
  logic [1:0]    op_size;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [AW-1:0] op_idx;
  logic [3:0]    op_be;
  logic [31:0]   op_wd;
  logic          op_err;
  logic          commit;

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
    logic e;
    e = 1'b0;
    if (sz == 2'b11)                         e = 1'b1;
    if (sz == 2'b01 && a[0])                 e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00)      e = 1'b1;
    if (a >= LIMIT)                          e = 1'b1;
    return e;
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // replicate the right-justified data so every lane sees its own bytes
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // In IDLE the live inputs drive the operation (LATENCY=0 and error paths);
  // afterwards the captured request does.
  always_comb begin
    op_we    = (state == IDLE) ? we    : we_p0;
    op_size  = (state == IDLE) ? size  : size_p0;
    op_addr  = (state == IDLE) ? addr  : addr_p0;
    op_wdata = (state == IDLE) ? wdata : wdata_p0;
    op_idx   = op_addr[AW+1:2];
    op_be    = lane_en(op_size, op_addr[1:0]);
    op_wd    = lane_data(op_size, op_wdata);
    op_err   = is_err(op_size, op_addr);
    commit   = 1'b0;
    if (state == IDLE && req && !op_err && NO_WAIT) commit = 1'b1;
    if (state == WAIT && cnt == 4'd0)               commit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_p0    <= we;
      size_p0  <= size;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && op_we) begin
      for (int l = 0; l < 4; l++)
        if (op_be[l]) mem[op_idx][8*l +: 8] <= op_wd[8*l +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (op_err) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else if (NO_WAIT) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b0;
              rdata <= op_we ? 32'd0 : mem[op_idx];
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            ready <= 1'b1;
            err   <= 1'b0;
            rdata <= op_we ? 32'd0 : mem[op_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [1:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ready_s [2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];

  int total = 0;
  int passed = 0;

  // unit 0: LATENCY=2, unit 1: LATENCY=0, both DEPTH=64
  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]), .rdata(rdata_s[0]),
    .err(err_s[0]));

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]), .rdata(rdata_s[1]),
    .err(err_s[1]));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  // reference memory contents, one image per unit
  logic [31:0] model [2][64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic clear_models();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) model[d][i] = 32'h0;
  endtask

  // behavioural model of one transaction: response and cycles to ready
  task automatic model_txn(input int d, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] erd, output logic eer, output int elat);
    int idx;
    int sh;
    logic [31:0] m;
    eer = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
          (sz == 2'd2 && (a % 4) != 0) || (a >= 32'd256);
    erd = 32'h0;
    if (eer) begin
      elat = 1;
    end else begin
      elat = ((d == 0) ? 2 : 0) + 1;
      idx = int'(a / 4);
      if (w) begin
        if (sz == 2'd0) begin
          sh = 8 * int'(a % 4);
          m = 32'hFF << sh;
          model[d][idx] = (model[d][idx] & ~m) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
          sh = 8 * int'(a % 4);
          m = 32'hFFFF << sh;
          model[d][idx] = (model[d][idx] & ~m) | ((wd & 32'hFFFF) << sh);
        end else begin
          model[d][idx] = wd;
        end
      end else begin
        erd = model[d][idx];
      end
    end
  endtask

  // issue one request from IDLE and return what the DUT answered
  task automatic do_req(input int d, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic quiet_bad;
    quiet_bad = 1'b0;
    @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = w; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    #1 req_s[d] = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ready_s[d]) begin
        lat = k; rd = rdata_s[d]; er = err_s[d];
        break;
      end
      if (err_s[d] !== 1'b0 || rdata_s[d] !== 32'h0) quiet_bad = 1'b1;
    end
    @(negedge clk);
    if (err_s[d] !== 1'b0 || rdata_s[d] !== 32'h0) quiet_bad = 1'b1;
    check("ready_one_cycle", 32'(ready_s[d]), 32'h0);
    check("outputs_zero_outside_resp", 32'(quiet_bad), 32'h0);
  endtask

  task automatic txn_check(input string tag, input int d, input logic w, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd, erd;
    logic er, eer;
    int lat, elat;
    do_req(d, w, sz, a, wd, rd, er, lat);
    model_txn(d, w, sz, a, wd, erd, eer, elat);
    check({tag, "_rdata"}, rd, erd);
    check({tag, "_err"}, 32'(er), 32'(eer));
    check({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
    int          elat;
  } vec_t;

  vec_t tbl[15];

  logic [31:0] rd_v, erd_v;
  logic        er_v, eer_v;
  int          lat_v, elat_v;
  int          gap, got, pulses;
  logic [1:0]  rsz;
  logic [31:0] ra;

  initial begin
    tbl[0]  = '{1'b1, 2'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 3};
    tbl[1]  = '{1'b0, 2'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3};
    tbl[2]  = '{1'b1, 2'd0, 32'h11,  32'h000000AB, 32'h0,        1'b0, 3};
    tbl[3]  = '{1'b0, 2'd2, 32'h10,  32'h0,        32'hDEADABEF, 1'b0, 3};
    tbl[4]  = '{1'b1, 2'd1, 32'h22,  32'h00001234, 32'h0,        1'b0, 3};
    tbl[5]  = '{1'b0, 2'd2, 32'h20,  32'h0,        32'h12340000, 1'b0, 3};
    tbl[6]  = '{1'b0, 2'd2, 32'h06,  32'h0,        32'h0,        1'b1, 1};
    tbl[7]  = '{1'b0, 2'd3, 32'h10,  32'h0,        32'h0,        1'b1, 1};
    tbl[8]  = '{1'b1, 2'd3, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1, 1};
    tbl[9]  = '{1'b0, 2'd2, 32'h10,  32'h0,        32'hDEADABEF, 1'b0, 3};
    tbl[10] = '{1'b0, 2'd2, 32'h100, 32'h0,        32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, 2'd1, 32'h13,  32'h0000FFFF, 32'h0,        1'b1, 1};
    tbl[12] = '{1'b0, 2'd0, 32'h23,  32'h0,        32'h12340000, 1'b0, 3};
    tbl[13] = '{1'b1, 2'd2, 32'hFC,  32'hCAFEF00D, 32'h0,        1'b0, 3};
    tbl[14] = '{1'b0, 2'd2, 32'hFC,  32'h0,        32'hCAFEF00D, 1'b0, 3};

    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; we_s[d] = 1'b0; size_s[d] = 2'd0; addr_s[d] = 32'h0; wdata_s[d] = 32'h0;
    end
    clear_models();

    // reset state, before any clock edge
    #1;
    check("reset_ready", 32'(ready_s[0]), 32'h0);
    check("reset_err", 32'(err_s[0]), 32'h0);
    check("reset_rdata", rdata_s[0], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // directed vectors on the LATENCY=2 unit
    for (int i = 0; i < 15; i++) begin
      do_req(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, rd_v, er_v, lat_v);
      model_txn(0, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, erd_v, eer_v, elat_v);
      check($sformatf("vec%0d_rdata", i), rd_v, tbl[i].erd);
      check($sformatf("vec%0d_err", i), 32'(er_v), 32'(tbl[i].eer));
      check($sformatf("vec%0d_latency", i), 32'(lat_v), 32'(tbl[i].elat));
    end

    // reset lands while a read response is on the bus: outputs drop at once
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b0; size_s[0] = 2'd2; addr_s[0] = 32'h10;
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    for (int k = 0; k < 10 && !ready_s[0]; k++) @(negedge clk);
    check("resp_before_reset_rdata", rdata_s[0], 32'hDEADABEF);
    #1 reset = 1'b0;
    #1;
    check("async_reset_ready", 32'(ready_s[0]), 32'h0);
    check("async_reset_rdata", rdata_s[0], 32'h0);
    @(negedge clk);
    reset = 1'b1;
    clear_models();
    txn_check("after_reset_read10", 0, 1'b0, 2'd2, 32'h10, 32'h0);

    // reset during WAIT of a write: no response, no memory change
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; size_s[0] = 2'd2; addr_s[0] = 32'h30; wdata_s[0] = 32'hA5A5A5A5;
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    #2 reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready_s[0]) pulses++;
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready_s[0]) pulses++;
    end
    check("wait_reset_no_ready", 32'(pulses), 32'h0);
    txn_check("wait_reset_read30", 0, 1'b0, 2'd2, 32'h30, 32'h0);

    // req held high: one response per LATENCY+2 cycles, each item exactly once
    @(negedge clk);
    got = 0; gap = 0;
    req_s[0] = 1'b1; we_s[0] = 1'b1; size_s[0] = 2'd2; addr_s[0] = 32'h80; wdata_s[0] = 32'h11110000;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      gap++;
      if (ready_s[0]) begin
        check($sformatf("held_gap%0d", got), 32'(gap), (got == 0) ? 32'd3 : 32'd4);
        got++;
        gap = 0;
        if (got < 4) begin
          addr_s[0] = 32'h80 + 32'(4 * got);
          wdata_s[0] = 32'h11110000 + 32'(got);
        end else begin
          req_s[0] = 1'b0;
        end
      end
    end
    req_s[0] = 1'b0;
    check("held_count", 32'(got), 32'd4);
    for (int k = 0; k < 4; k++) model[0][32 + k] = 32'h11110000 + 32'(k);
    txn_check("held_read7c", 0, 1'b0, 2'd2, 32'h7C, 32'h0);
    for (int k = 0; k < 4; k++)
      txn_check($sformatf("held_read%0d", k), 0, 1'b0, 2'd2, 32'h80 + 32'(4 * k), 32'h0);

    // LATENCY=0 unit
    txn_check("l0_wr40", 1, 1'b1, 2'd2, 32'h40, 32'h55AA55AA);
    txn_check("l0_rd40", 1, 1'b0, 2'd2, 32'h40, 32'h0);
    txn_check("l0_wrb43", 1, 1'b1, 2'd0, 32'h43, 32'h000000C3);
    txn_check("l0_rd40b", 1, 1'b0, 2'd2, 32'h40, 32'h0);
    txn_check("l0_illegal", 1, 1'b0, 2'd3, 32'h40, 32'h0);
    txn_check("l0_oor", 1, 1'b1, 2'd2, 32'h100, 32'h12345678);

    // randomized traffic against the model
    for (int n = 0; n < 160; n++) begin
      int d;
      d = (n % 4 == 3) ? 1 : 0;
      rsz = 2'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 70)) * 32'd4;
      if ($urandom_range(0, 4) == 0) ra = ra + 32'($urandom_range(0, 3));
      else if (rsz == 2'd0) ra = ra + 32'($urandom_range(0, 3));
      else if (rsz == 2'd1) ra = ra + 32'(2 * $urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) ra = 32'hFFFFFF00 | ra;
      txn_check($sformatf("rnd%0d", n), d, 1'($urandom_range(0, 1)), rsz, ra, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
